// File: rtl/multiport_regfile_if.sv
// Register-file access bundle: read ports, write ports, scoreboard set and pending count.
// The master side issues addresses, writes and sets. The slave side returns read data and pending state.
interface regfile_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 4,
    parameter int NUM_WRITE  = 2
);
    logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr;
    logic [NUM_READ*WIDTH-1:0]       rd_data;
    logic [NUM_READ-1:0]             rd_pending;
    logic [NUM_WRITE-1:0]            wr_en;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WRITE*WIDTH-1:0]      wr_data;
    logic                            sb_set_en;
    logic [ADDR_WIDTH-1:0]           sb_set_addr;
    logic [ADDR_WIDTH:0]             pending_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        input  rd_data, rd_pending, pending_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        output rd_data, rd_pending, pending_cnt
    );
endinterface

// File: rtl/multiport_regfile.sv
// Multiport register file with a per-register pending scoreboard. Reads are combinational, and writes and sets land on the clock edge.
// There is no backpressure. Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module multiport_regfile #(
    parameter int                WIDTH      = 32,
    parameter int                ADDR_WIDTH = 5,
    parameter int                NUM_READ   = 4,
    parameter int                NUM_WRITE  = 2,
    parameter logic [WIDTH-1:0]  GP_INIT    = WIDTH'(32'h00001800),
    parameter logic [WIDTH-1:0]  SP_INIT    = WIDTH'(32'h00002ffe)
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]        regs_q [DEPTH];
    logic [WIDTH-1:0]        regs_d [DEPTH];
    logic [DEPTH-1:0]        pend_q;
    logic [DEPTH-1:0]        pend_d;
    logic [ADDR_WIDTH:0]     cnt_q;
    logic [ADDR_WIDTH:0]     cnt_d;
    logic [NUM_READ*WIDTH-1:0] rd_data_c;
    logic [NUM_READ-1:0]     rd_pend_c;

    function automatic logic [WIDTH-1:0] init_val(input int idx);
        if (idx == 28) return GP_INIT;
        if (idx == 29) return SP_INIT;
        return '0;
    endfunction

    // Writes are applied in ascending port order so the highest port wins a collision; the set is applied last so it beats a clear.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (bus.wr_en[w] && (bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                regs_d[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = bus.wr_data[w*WIDTH +: WIDTH];
                pend_d[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (bus.sb_set_en && (bus.sb_set_addr != '0)) begin
            pend_d[bus.sb_set_addr] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + (ADDR_WIDTH+1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= init_val(i);
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_pend_c = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            rd_data_c[r*WIDTH +: WIDTH] = regs_q[bus.rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            rd_pend_c[r]                = pend_q[bus.rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (bus.wr_en[w] && (bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
                    (bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == bus.rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    rd_data_c[r*WIDTH +: WIDTH] = bus.wr_data[w*WIDTH +: WIDTH];
                    rd_pend_c[r] = bus.sb_set_en &&
                                   (bus.sb_set_addr == bus.rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]);
                end
            end
`endif
            // Reset blanks the read side combinationally, so initial register values stay hidden until release.
            if (rst) begin
                rd_data_c[r*WIDTH +: WIDTH] = '0;
                rd_pend_c[r]                = 1'b0;
            end
        end
    end

    assign bus.rd_data     = rd_data_c;
    assign bus.rd_pending  = rd_pend_c;
    assign bus.pending_cnt = cnt_q;
endmodule

// File: tb/tb_multiport_regfile.sv
module tb_multiport_regfile;
    localparam int W = 32, AW = 5, NR = 4, NW = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    regfile_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW)) bus();

    multiport_regfile #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rdat(input int k);
        return bus.rd_data[k*W +: W];
    endfunction

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        bus.rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_rd_all(input logic [AW-1:0] a);
        for (int k = 0; k < NR; k++) bus.rd_addr[k*AW +: AW] = a;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.wr_en[p]            = 1'b1;
        bus.wr_addr[p*AW +: AW] = a;
        bus.wr_data[p*W +: W]   = d;
    endtask

    task automatic sb(input logic [AW-1:0] a);
        bus.sb_set_en   = 1'b1;
        bus.sb_set_addr = a;
    endtask

    task automatic idle();
        bus.wr_en     = '0;
        bus.sb_set_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] addrs [3];
        logic [W-1:0]  exps  [3];
        addrs = '{5'd28, 5'd29, 5'd5};
        exps  = '{32'h00001800, 32'h00002ffe, 32'h0};
        rst = 1'b1;
        idle();
        bus.wr_addr = '0; bus.wr_data = '0; bus.sb_set_addr = '0;
        set_rd_all(5'd28);
        #2;
        n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL rst_hold_data got %h exp 0", bus.rd_data); end
        n_cmp++; if (bus.pending_cnt !== 6'd0) begin n_bad++; $display("FAIL rst_hold_cnt got %0d exp 0", bus.pending_cnt); end
        n_cmp++; if (bus.rd_pending !== 4'h0) begin n_bad++; $display("FAIL rst_hold_pend got %b exp 0", bus.rd_pending); end
        #5 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            set_rd_all(addrs[i]);
            #1;
            for (int k = 0; k < NR; k++) begin
                n_cmp++;
                if (rdat(k) !== exps[i]) begin
                    n_bad++; $display("FAIL reset_val addr %0d port %0d got %h exp %h", addrs[i], k, rdat(k), exps[i]);
                end
            end
            n_cmp++; if (bus.rd_pending !== 4'h0) begin n_bad++; $display("FAIL reset_pend addr %0d got %b exp 0", addrs[i], bus.rd_pending); end
        end
        n_cmp++; if (bus.pending_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", bus.pending_cnt); end
    endtask

    task automatic test_collision();
        @(posedge clk); #1;
        wr(0, 5'd7, 32'hAAAA0000); wr(1, 5'd7, 32'h5555FFFF);
        set_rd(0, 5'd7); set_rd(1, 5'd7);
        @(negedge clk);
        n_cmp++; if (rdat(0) !== (BYP ? 32'h5555FFFF : 32'h0)) begin n_bad++; $display("FAIL coll_same_cycle got %h exp %h", rdat(0), (BYP ? 32'h5555FFFF : 32'h0)); end
        @(posedge clk); #1;
        idle(); #1;
        n_cmp++; if (rdat(1) !== 32'h5555FFFF) begin n_bad++; $display("FAIL coll_winner got %h exp 5555ffff", rdat(1)); end
        wr(0, 5'd10, 32'h10101010); wr(1, 5'd11, 32'h11111111);
        @(posedge clk); #1;
        idle(); set_rd(0, 5'd10); set_rd(1, 5'd11); #1;
        n_cmp++; if (rdat(0) !== 32'h10101010) begin n_bad++; $display("FAIL wr_port0 got %h exp 10101010", rdat(0)); end
        n_cmp++; if (rdat(1) !== 32'h11111111) begin n_bad++; $display("FAIL wr_port1 got %h exp 11111111", rdat(1)); end
    endtask

    task automatic test_scoreboard();
        @(posedge clk); #1;
        sb(5'd3); set_rd(0, 5'd3);
        @(negedge clk);
        n_cmp++; if (bus.rd_pending[0] !== 1'b0) begin n_bad++; $display("FAIL sb_before_edge got %b exp 0", bus.rd_pending[0]); end
        @(posedge clk); #1;
        n_cmp++; if (bus.rd_pending[0] !== 1'b1) begin n_bad++; $display("FAIL sb_set got %b exp 1", bus.rd_pending[0]); end
        n_cmp++; if (bus.pending_cnt !== 6'd1) begin n_bad++; $display("FAIL sb_set_cnt got %0d exp 1", bus.pending_cnt); end
        idle(); wr(0, 5'd3, 32'h12345678); sb(5'd3);
        @(negedge clk);
        n_cmp++; if (bus.rd_pending[0] !== 1'b1) begin n_bad++; $display("FAIL sb_setclr_comb got %b exp 1", bus.rd_pending[0]); end
        @(posedge clk); #1;
        idle(); #1;
        n_cmp++; if (bus.rd_pending[0] !== 1'b1) begin n_bad++; $display("FAIL sb_set_wins got %b exp 1", bus.rd_pending[0]); end
        n_cmp++; if (bus.pending_cnt !== 6'd1) begin n_bad++; $display("FAIL sb_set_wins_cnt got %0d exp 1", bus.pending_cnt); end
        n_cmp++; if (rdat(0) !== 32'h12345678) begin n_bad++; $display("FAIL sb_data got %h exp 12345678", rdat(0)); end
        wr(1, 5'd3, 32'h87654321);
        @(posedge clk); #1;
        idle(); #1;
        n_cmp++; if (bus.rd_pending[0] !== 1'b0) begin n_bad++; $display("FAIL sb_clear got %b exp 0", bus.rd_pending[0]); end
        n_cmp++; if (bus.pending_cnt !== 6'd0) begin n_bad++; $display("FAIL sb_clear_cnt got %0d exp 0", bus.pending_cnt); end
        n_cmp++; if (rdat(0) !== 32'h87654321) begin n_bad++; $display("FAIL sb_clear_data got %h exp 87654321", rdat(0)); end
    endtask

    task automatic test_bypass();
        @(posedge clk); #1;
        wr(0, 5'd9, 32'h11111111); sb(5'd9); set_rd(0, 5'd9); set_rd(1, 5'd7);
        @(posedge clk); #1;
        idle(); wr(1, 5'd9, 32'hDEADBEEF);
        @(negedge clk);
        n_cmp++; if (rdat(0) !== (BYP ? 32'hDEADBEEF : 32'h11111111)) begin n_bad++; $display("FAIL byp_data got %h exp %h", rdat(0), (BYP ? 32'hDEADBEEF : 32'h11111111)); end
        n_cmp++; if (bus.rd_pending[0] !== !BYP) begin n_bad++; $display("FAIL byp_pend got %b exp %b", bus.rd_pending[0], !BYP); end
        n_cmp++; if (rdat(1) !== 32'h5555FFFF) begin n_bad++; $display("FAIL byp_other_port got %h exp 5555ffff", rdat(1)); end
        @(posedge clk); #1;
        n_cmp++; if (bus.pending_cnt !== 6'd0) begin n_bad++; $display("FAIL byp_cnt_clear got %0d exp 0", bus.pending_cnt); end
        idle(); wr(0, 5'd9, 32'hCAFEF00D); sb(5'd9);
        @(negedge clk);
        n_cmp++; if (rdat(0) !== (BYP ? 32'hCAFEF00D : 32'hDEADBEEF)) begin n_bad++; $display("FAIL byp_set_data got %h exp %h", rdat(0), (BYP ? 32'hCAFEF00D : 32'hDEADBEEF)); end
        n_cmp++; if (bus.rd_pending[0] !== BYP) begin n_bad++; $display("FAIL byp_set_pend got %b exp %b", bus.rd_pending[0], BYP); end
        @(posedge clk); #1;
        idle(); #1;
        n_cmp++; if (bus.rd_pending[0] !== 1'b1) begin n_bad++; $display("FAIL byp_after_pend got %b exp 1", bus.rd_pending[0]); end
        n_cmp++; if (bus.pending_cnt !== 6'd1) begin n_bad++; $display("FAIL byp_after_cnt got %0d exp 1", bus.pending_cnt); end
        wr(0, 5'd9, 32'h0);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_zero();
        @(posedge clk); #1;
        sb(5'd12);
        @(posedge clk); #1;
        idle(); wr(0, 5'd0, 32'hFFFFFFFF); wr(1, 5'd0, 32'hFFFFFFFF); sb(5'd0); set_rd_all(5'd0);
        @(negedge clk);
        n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL zero_comb_data got %h exp 0", bus.rd_data); end
        n_cmp++; if (bus.rd_pending !== 4'h0) begin n_bad++; $display("FAIL zero_comb_pend got %b exp 0", bus.rd_pending); end
        @(posedge clk); #1;
        idle(); #1;
        n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL zero_data got %h exp 0", bus.rd_data); end
        n_cmp++; if (bus.rd_pending !== 4'h0) begin n_bad++; $display("FAIL zero_pend got %b exp 0", bus.rd_pending); end
        n_cmp++; if (bus.pending_cnt !== 6'd1) begin n_bad++; $display("FAIL zero_cnt got %0d exp 1", bus.pending_cnt); end
        wr(0, 5'd12, 32'h0);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        wr(0, 5'd4, 32'h44); wr(1, 5'd6, 32'h66);
        @(posedge clk); #1;
        idle(); sb(5'd4);
        @(posedge clk); #1;
        idle(); sb(5'd6);
        @(posedge clk); #1;
        idle(); set_rd(0, 5'd4); set_rd(1, 5'd6); set_rd(2, 5'd28); #1;
        n_cmp++; if (bus.pending_cnt !== 6'd2) begin n_bad++; $display("FAIL arst_pre_cnt got %0d exp 2", bus.pending_cnt); end
        n_cmp++; if (rdat(0) !== 32'h44) begin n_bad++; $display("FAIL arst_pre_data got %h exp 44", rdat(0)); end
        wr(0, 5'd4, 32'h99); sb(5'd5);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL arst_data got %h exp 0", bus.rd_data); end
        n_cmp++; if (bus.pending_cnt !== 6'd0) begin n_bad++; $display("FAIL arst_cnt got %0d exp 0", bus.pending_cnt); end
        n_cmp++; if (bus.rd_pending !== 4'h0) begin n_bad++; $display("FAIL arst_pend got %b exp 0", bus.rd_pending); end
        idle();
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_cmp++; if (rdat(0) !== 32'h0) begin n_bad++; $display("FAIL arst_r4 got %h exp 0", rdat(0)); end
        n_cmp++; if (rdat(1) !== 32'h0) begin n_bad++; $display("FAIL arst_r6 got %h exp 0", rdat(1)); end
        n_cmp++; if (rdat(2) !== 32'h00001800) begin n_bad++; $display("FAIL arst_r28 got %h exp 1800", rdat(2)); end
        n_cmp++; if (bus.pending_cnt !== 6'd0) begin n_bad++; $display("FAIL arst_post_cnt got %0d exp 0", bus.pending_cnt); end
        @(posedge clk); #1;
        rst = 1'b1;
        wr(0, 5'd5, 32'h55);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        idle(); set_rd(3, 5'd5); #1;
        n_cmp++; if (rdat(3) !== 32'h55) begin n_bad++; $display("FAIL first_write_after_rst got %h exp 55", rdat(3)); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_collision();
        test_scoreboard();
        test_bypass();
        test_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 The block SHALL take these parameters, one per line (name, default, meaning):
- WIDTH, 32, data bits per register.
- ADDR_WIDTH, 5, register address bits; depth = 2^ADDR_WIDTH.
- NUM_READ, 4, number of read ports.
- NUM_WRITE, 2, number of write ports.
- GP_INIT, 32'h00001800, reset value of register 28.
- SP_INIT, 32'h00002ffe, reset value of register 29.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- rd_addr, in, NUM_READ*ADDR_WIDTH, packed read addresses; port k at slice k.
- rd_data, out, NUM_READ*WIDTH, packed read data.
- rd_pending, out, NUM_READ, 1 = addressed register awaits an outstanding write.
- wr_en, in, NUM_WRITE, per-port write enable.
- wr_addr, in, NUM_WRITE*ADDR_WIDTH, packed write addresses.
- wr_data, in, NUM_WRITE*WIDTH, packed write data.
- sb_set_en, in, 1, mark sb_set_addr pending (issue of a producer).
- sb_set_addr, in, ADDR_WIDTH, register to mark pending.
- pending_cnt, out, ADDR_WIDTH+1, number of registers currently pending.

Function
REQ-003 Reads SHALL be combinational, with zero latency, on every port independently.
REQ-004 Register 0 SHALL read as 0, SHALL ignore writes, and SHALL never be pending; sb_set_en to address 0 is a no-op.
REQ-005 Each write port with wr_en=1 and a non-zero address SHALL update its register on the rising clk edge.
REQ-006 Write collision on the same address in the same cycle: the highest-index port SHALL win.
REQ-007 The scoreboard SHALL hold one pending bit per register, set on the clk edge by sb_set_en and cleared on the clk edge by any enabled write to that register.
REQ-008 Simultaneous set and clear of the same register SHALL leave it pending, because set wins (a new producer supersedes the old one).
REQ-009 pending_cnt SHALL equal the registered population count of the pending bits, updated on the same edge as those bits.
REQ-010 Read-port bypass behaviour SHALL follow REQ-016 and REQ-017.

Reset
REQ-011 While rst=1, all registers SHALL be 0 except register 28 = GP_INIT and register 29 = SP_INIT.
REQ-012 While rst=1, all pending bits SHALL be 0, pending_cnt SHALL be 0, rd_data SHALL be all 0 and rd_pending SHALL be all 0, independent of clk.
REQ-013 Assertion of rst mid-operation SHALL take effect immediately, discarding in-flight writes and sets of that cycle.
REQ-014 The first write after rst deasserts SHALL take effect on the first rising clk edge that sees rst=0.

Configuration
REQ-015 The macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-016 With REGFILE_BYPASS_EN defined, a read address matching an enabled same-cycle write (non-zero address) SHALL return that write's wr_data, using the highest-index matching port.
REQ-017 With REGFILE_BYPASS_EN defined, the rd_pending of such a matching read port SHALL be 0 unless sb_set_en targets the same address in that cycle.
REQ-018 Without REGFILE_BYPASS_EN, reads SHALL return stored contents only and rd_pending SHALL reflect stored bits only; new data becomes visible one cycle after the write.

Verification
REQ-019 Pulse rst, then read all ports at addresses 28, 29, 5 -> 0x00001800, 0x00002ffe, 0, with rd_pending=0 and pending_cnt=0.
REQ-020 In one cycle, write port0 addr 7=0xAAAA0000 and port1 addr 7=0x5555FFFF -> register 7 reads 0x5555FFFF on the next cycle.
REQ-021 sb_set addr 3; next cycle, write addr 3=0x12345678 with sb_set addr 3 in the same cycle -> register 3 still pending, pending_cnt=1, data 0x12345678 stored.
REQ-022 Bypass build: write addr 9=0xDEADBEEF while reading addr 9 with 9 pending -> rd_data=0xDEADBEEF and rd_pending=0 that cycle; non-bypass build returns the old value with rd_pending=1.
REQ-023 Write addr 0=0xFFFFFFFF and sb_set addr 0 -> reads of addr 0 return 0, rd_pending=0, pending_cnt unchanged.
REQ-024 Assert rst asynchronously between edges while registers 4 and 6 are pending -> rd_data and pending_cnt go to 0 immediately, and register 4 reads 0 after release.
